hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage segmented core.
- Generates per-latch write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM from three event sources:
  - MEM-stage branch resolution (EX/MEM branchBit/aluZero)
  - ID-stage load-use hazards
  - data-memory wait handshake
- Tracks memory-wait with a small FSM and exposes saturating stall/flush performance counters plus a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer:
// FSM encoding, register-zero index and the control-word presets.
package hazard_ctrl_pkg;

  localparam int          DEF_CNT_W = 16;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_src;
  } ctrl_t;

  // Latch-clearing word driven while reset is held: capture everything, flush everything.
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                   exmem_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                                   exmem_flush: 1'b1, pc_src: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '0;
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                    exmem_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                                    exmem_flush: 1'b1, pc_src: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                    exmem_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1,
                                    exmem_flush: 1'b0, pc_src: 1'b0};
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                 exmem_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                                 exmem_flush: 1'b0, pc_src: 1'b0};

  function automatic logic load_use(input logic       ex_mem_read,
                                    input logic [4:0] ex_dest,
                                    input logic [4:0] id_rs1,
                                    input logic [4:0] id_rs2);
    return ex_mem_read && (ex_dest != REG_ZERO) &&
           ((ex_dest == id_rs1) || (ex_dest == id_rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: per-latch write/flush controls from branch, load-use and
// memory-wait events, a memory-wait FSM with timeout, and stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK_i,
  input  logic             RSTn_i,
  input  logic [4:0]       idRs1_i,
  input  logic [4:0]       idRs2_i,
  input  logic             exMemRead_i,
  input  logic [4:0]       exRegDest_i,
  input  logic             memBranch_i,
  input  logic             memAluZero_i,
  input  logic             memRead_i,
  input  logic             memWrite_i,
  input  logic             dmemReady_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEXWrite_o,
  output logic             EXMEMWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXFlush_o,
  output logic             EXMEMFlush_o,
  output logic             PCSrc_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o,
  output logic             memTimeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             w_mem_busy;
  logic             w_br_taken;
  logic             w_ld_use;
  logic             w_stall_inc;
  logic             w_flush_inc;
  ctrl_t            w_ctrl;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0] w_wait_inc;
  logic             r_timeout;
  logic             w_timeout_nxt;

  assign w_mem_busy = (memRead_i | memWrite_i) & ~dmemReady_i;
  assign w_br_taken = memBranch_i & memAluZero_i;
  assign w_ld_use   = load_use(exMemRead_i, exRegDest_i, idRs1_i, idRs2_i);

  // A stalled cycle counts once; a load-use under a taken branch is flushed, not stalled.
  assign w_stall_inc = w_mem_busy | (w_ld_use & ~w_br_taken);
  assign w_flush_inc = w_br_taken & ~w_mem_busy;

  // Controls depend only on the live events: MEM_WAIT and ERR freeze purely through memBusy.
  always_comb begin
    // NOTE: default first so every path assigns w_ctrl and no latch is inferred.
    w_ctrl = CTRL_RUN;
    if (!RSTn_i) begin
      w_ctrl = CTRL_RESET;
    end else if (w_mem_busy) begin
      w_ctrl = CTRL_FREEZE;
    end else if (w_br_taken) begin
      w_ctrl = CTRL_BRANCH;
    end else if (w_ld_use) begin
      w_ctrl = CTRL_BUBBLE;
    end
  end

  assign PCWrite_o    = w_ctrl.pc_write;
  assign IFIDWrite_o  = w_ctrl.ifid_write;
  assign IDEXWrite_o  = w_ctrl.idex_write;
  assign EXMEMWrite_o = w_ctrl.exmem_write;
  assign IFIDFlush_o  = w_ctrl.ifid_flush;
  assign IDEXFlush_o  = w_ctrl.idex_flush;
  assign EXMEMFlush_o = w_ctrl.exmem_flush;
  assign PCSrc_o      = w_ctrl.pc_src;

  assign w_wait_inc = r_wait_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_MEM_WAIT: begin
        if (w_mem_busy) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == TIMEOUT_C) begin
            w_state_nxt   = ST_ERR;
            w_timeout_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        // Unused encoding 3 behaves as RUN.
        w_state_nxt = ST_RUN;
        if (w_mem_busy) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign state_o      = r_state;
  assign memTimeout_o = r_timeout;

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (CLK_i),
    .i_clr_n (RSTn_i),
    .i_inc   (w_stall_inc),
    .o_count (stallCnt_o)
  );

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (CLK_i),
    .i_clr_n (RSTn_i),
    .i_inc   (w_flush_inc),
    .o_count (flushCnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl (CNT_W=3, TIMEOUT=4) against a
// cycle-level reference model of the sequencer rules.
module tb_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_reg_dest;
  logic             ex_mem_read, mem_branch, mem_alu_zero, mem_read, mem_write, dmem_ready;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_flush, exmem_flush, pc_src;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK_i        (clk),
    .RSTn_i       (rst_n),
    .idRs1_i      (id_rs1),
    .idRs2_i      (id_rs2),
    .exMemRead_i  (ex_mem_read),
    .exRegDest_i  (ex_reg_dest),
    .memBranch_i  (mem_branch),
    .memAluZero_i (mem_alu_zero),
    .memRead_i    (mem_read),
    .memWrite_i   (mem_write),
    .dmemReady_i  (dmem_ready),
    .PCWrite_o    (pc_write),
    .IFIDWrite_o  (ifid_write),
    .IDEXWrite_o  (idex_write),
    .EXMEMWrite_o (exmem_write),
    .IFIDFlush_o  (ifid_flush),
    .IDEXFlush_o  (idex_flush),
    .EXMEMFlush_o (exmem_flush),
    .PCSrc_o      (pc_src),
    .state_o      (state),
    .stallCnt_o   (stall_cnt),
    .flushCnt_o   (flush_cnt),
    .memTimeout_o (mem_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: wait state as 0=run,1=waiting,2=error, plain integer counters.
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {pc_write, ifid_write, idex_write, exmem_write,
            ifid_flush, idex_flush, exmem_flush, pc_src};
  endfunction

  function automatic bit ev_busy();
    return (mem_read || mem_write) && !dmem_ready;
  endfunction

  function automatic bit ev_br();
    return mem_branch && mem_alu_zero;
  endfunction

  function automatic bit ev_ld();
    return ex_mem_read && (ex_reg_dest != 5'd0) &&
           ((ex_reg_dest == id_rs1) || (ex_reg_dest == id_rs2));
  endfunction

  // Expected {PC,IFID,IDEX,EXMEM writes, IFID,IDEX,EXMEM flushes, PCSrc}.
  function automatic logic [7:0] exp_ctrl();
    if (!rst_n)    return 8'b1111_111_0;
    if (ev_busy()) return 8'b0000_000_0;
    if (ev_br())   return 8'b1111_111_1;
    if (ev_ld())   return 8'b0011_010_0;
    return 8'b1111_000_0;
  endfunction

  task automatic check_model();
    check("ctrl", 16'(obs_ctrl()), 16'(exp_ctrl()));
    if (m_valid) begin
      check("state",   16'(state),       16'(m_state));
      check("stall",   16'(stall_cnt),   16'(m_stall));
      check("flush",   16'(flush_cnt),   16'(m_flush));
      check("timeout", 16'(mem_timeout), 16'(m_to));
    end
  endtask

  task automatic model_update();
    bit busy, br, ld;
    busy = ev_busy();
    br   = ev_br();
    ld   = ev_ld();
    if (!rst_n) begin
      m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 1'b0; m_valid = 1'b1;
    end else begin
      if (busy || (ld && !br)) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (br && !busy)         m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_state == 0) begin
        if (busy) begin
          m_state = 1;
          m_wait  = 0;
        end
      end else if (m_state == 1) begin
        if (!busy) begin
          m_state = 0;
        end else begin
          m_wait = m_wait + 1;
          if (m_wait == TIMEOUT) begin
            m_state = 2;
            m_to    = 1'b1;
          end
        end
      end
    end
  endtask

  // Called at negedge+1 with inputs settled; returns positioned at the next negedge.
  task automatic tick();
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst_n = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_mem_read = 1'b0; ex_reg_dest = '0;
    mem_branch = 1'b0; mem_alu_zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset: latches cleared by capture+flush
    #1; check("rst_ctrl", 16'(obs_ctrl()), 16'h00FE);
    tick();
    #1; tick();
    rst_n = 1'b1;
    #1;
    check("idle_ctrl",  16'(obs_ctrl()),  16'h00F0);
    check("idle_state", 16'(state),       16'd0);
    check("idle_stall", 16'(stall_cnt),   16'd0);
    check("idle_flush", 16'(flush_cnt),   16'd0);
    check("idle_to",    16'(mem_timeout), 16'd0);
    tick();

    // Load-use bubble
    ex_mem_read = 1'b1; ex_reg_dest = 5'd5; id_rs2 = 5'd5;
    #1; check("ldu_ctrl", 16'(obs_ctrl()), 16'h0034);
    tick();
    ex_reg_dest = 5'd0; id_rs2 = 5'd0;
    #1;
    check("ldu_stall",  16'(stall_cnt),  16'd1);
    check("ldu_x0_ctrl", 16'(obs_ctrl()), 16'h00F0);
    tick();
    set_idle();
    #1; check("ldu_x0_stall", 16'(stall_cnt), 16'd1);
    tick();

    // Taken branch overrides a coincident load-use
    mem_branch = 1'b1; mem_alu_zero = 1'b1;
    ex_mem_read = 1'b1; ex_reg_dest = 5'd5; id_rs2 = 5'd5;
    #1; check("br_ctrl", 16'(obs_ctrl()), 16'h00FF);
    tick();
    set_idle();
    #1;
    check("br_flush", 16'(flush_cnt), 16'd1);
    check("br_stall", 16'(stall_cnt), 16'd1);
    tick();

    // Memory wait: three busy cycles, then ready
    mem_read = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check("mw_ctrl", 16'(obs_ctrl()), 16'h0000);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("mw_state",     16'(state),      16'd1);
    check("mw_rdy_ctrl",  16'(obs_ctrl()), 16'h00F0);
    check("mw_stall",     16'(stall_cnt),  16'd4);
    tick();
    set_idle();
    #1; check("mw_back_run", 16'(state), 16'd0);
    tick();

    // Timeout after TIMEOUT waiting cycles, sticky until reset
    rst_n = 1'b0;
    #1; tick();
    set_idle();
    mem_write = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1; tick();
    end
    #1;
    check("to_pre_state", 16'(state),       16'd1);
    check("to_pre_flag",  16'(mem_timeout), 16'd0);
    tick();
    #1;
    check("to_state", 16'(state),       16'd2);
    check("to_flag",  16'(mem_timeout), 16'd1);
    dmem_ready = 1'b1;
    #1; check("to_rdy_ctrl", 16'(obs_ctrl()), 16'h00F0);
    tick();
    mem_write = 1'b0;
    #1;
    check("to_sticky_state", 16'(state),       16'd2);
    check("to_sticky_flag",  16'(mem_timeout), 16'd1);
    tick();
    rst_n = 1'b0;
    #1; tick();
    set_idle();
    #1;
    check("to_clr_state", 16'(state),       16'd0);
    check("to_clr_flag",  16'(mem_timeout), 16'd0);
    tick();

    // Stall counter saturation
    ex_mem_read = 1'b1; ex_reg_dest = 5'd7; id_rs1 = 5'd7;
    for (int i = 0; i < 10; i++) begin
      #1; tick();
    end
    set_idle();
    #1; check("sat_stall", 16'(stall_cnt), 16'(CNT_MAX));
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_reg_dest  = 5'($urandom_range(0, 3));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_branch   = 1'($urandom_range(0, 1));
      mem_alu_zero = 1'($urandom_range(0, 1));
      mem_read     = ($urandom_range(0, 3) == 0);
      mem_write    = ($urandom_range(0, 5) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      #1; tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
